// File: rtl/multi_channel_peak_tracker.sv
// Multi-channel peak tracker: per-channel max/time capture and
// first threshold crossing over a fixed acquisition window.
module multi_channel_peak_tracker #(
    parameter  int DATA_W  = 10,
    parameter  int NUM_CH  = 4,
    parameter  int WIN_LEN = 1024,
    parameter  int CNT_W   = 16,
    localparam int CH_W    = $clog2(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      sample_valid,
    input  logic [CH_W-1:0]           sample_ch,
    input  logic [DATA_W-1:0]         sample_data,
    input  logic [DATA_W-1:0]         threshold,
    input  logic                      report_ready,
    output logic                      busy,
    output logic                      report_valid,
    output logic [NUM_CH*DATA_W-1:0]  peak_values,
    output logic [NUM_CH*CNT_W-1:0]   peak_times,
    output logic [CH_W-1:0]           first_ch,
    output logic                      first_hit,
    output logic [CNT_W-1:0]          first_time
);

    localparam int WIN_W = $clog2(WIN_LEN);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        REPORT
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] peak  [NUM_CH];
    logic [CNT_W-1:0]  ptime [NUM_CH];
    logic [DATA_W-1:0] thr;
    logic [CNT_W-1:0]  frame;
    logic [WIN_W-1:0]  win_cnt;

    logic accept_start;
    logic ch_ok;
    logic take;
    logic frame_end;
    logic win_done;

    assign accept_start = (state == IDLE) && start;
    assign ch_ok        = int'(sample_ch) < NUM_CH;
    assign take         = (state == ACQUIRE) && sample_valid && ch_ok;
    assign frame_end    = take && (sample_ch == CH_LAST);
    assign win_done     = frame_end && (win_cnt == WIN_LAST);

    assign busy         = (state != IDLE);
    assign report_valid = (state == REPORT);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACQUIRE;
            ACQUIRE: if (win_done) state_next = REPORT;
            REPORT:  if (report_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Peak, timestamp, first-crossing and frame tracking
    always_ff @(posedge clk) begin
        if (reset || accept_start) begin
            for (int k = 0; k < NUM_CH; k++) begin
                peak[k]  <= '0;
                ptime[k] <= '0;
            end
            thr        <= reset ? '0 : threshold;
            frame      <= '0;
            win_cnt    <= '0;
            first_hit  <= 1'b0;
            first_ch   <= '0;
            first_time <= '0;
        end else if (take) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (sample_ch == CH_W'(k) && sample_data > peak[k]) begin
                    peak[k]  <= sample_data;
                    ptime[k] <= frame;
                end
            end
            if (!first_hit && sample_data >= thr) begin
                first_hit  <= 1'b1;
                first_ch   <= sample_ch;
                first_time <= frame;
            end
            if (frame_end) begin
                frame   <= frame + CNT_W'(1);
                win_cnt <= win_cnt + WIN_W'(1);
            end
        end
    end

    // Flatten per-channel state onto the report buses
    always_comb begin
        peak_values = '0;
        peak_times  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            peak_values[k*DATA_W +: DATA_W] = peak[k];
            peak_times[k*CNT_W +: CNT_W]    = ptime[k];
        end
    end

endmodule

// File: tb/tb_multi_channel_peak_tracker.sv
// Scoreboard bench for multi_channel_peak_tracker: a 4-channel and a
// 3-channel instance, directed windows with hand-computed reports.
module tb_multi_channel_peak_tracker;

    typedef struct {
        logic [63:0] pv;
        logic [63:0] pt;
        logic        fh;
        logic [3:0]  fc;
        logic [15:0] ft;
    } rep_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-channel instance, WIN_LEN = 4
    logic        reset, start, sample_valid, report_ready;
    logic [1:0]  sample_ch;
    logic [9:0]  sample_data, threshold;
    logic        busy, report_valid, first_hit;
    logic [39:0] peak_values;
    logic [63:0] peak_times;
    logic [1:0]  first_ch;
    logic [15:0] first_time;

    multi_channel_peak_tracker #(
        .DATA_W(10), .NUM_CH(4), .WIN_LEN(4), .CNT_W(16)
    ) u4 (
        .clk(clk), .reset(reset), .start(start),
        .sample_valid(sample_valid), .sample_ch(sample_ch),
        .sample_data(sample_data), .threshold(threshold),
        .report_ready(report_ready), .busy(busy),
        .report_valid(report_valid), .peak_values(peak_values),
        .peak_times(peak_times), .first_ch(first_ch),
        .first_hit(first_hit), .first_time(first_time)
    );

    // 3-channel instance, WIN_LEN = 2
    logic        s3_reset, s3_start, s3_valid, s3_ready;
    logic [1:0]  s3_ch;
    logic [9:0]  s3_data, s3_thr;
    logic        s3_busy, s3_rv, s3_fh;
    logic [29:0] s3_pv;
    logic [47:0] s3_pt;
    logic [1:0]  s3_fc;
    logic [15:0] s3_ft;

    multi_channel_peak_tracker #(
        .DATA_W(10), .NUM_CH(3), .WIN_LEN(2), .CNT_W(16)
    ) u3 (
        .clk(clk), .reset(s3_reset), .start(s3_start),
        .sample_valid(s3_valid), .sample_ch(s3_ch),
        .sample_data(s3_data), .threshold(s3_thr),
        .report_ready(s3_ready), .busy(s3_busy),
        .report_valid(s3_rv), .peak_values(s3_pv),
        .peak_times(s3_pt), .first_ch(s3_fc),
        .first_hit(s3_fh), .first_time(s3_ft)
    );

    int   n_pass = 0;
    int   n_total = 0;
    rep_t q4[$];
    rep_t q3[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] pk(input int w, input int v0,
        input int v1, input int v2, input int v3);
        logic [63:0] r;
        r = 64'(v0) | (64'(v1) << w) | (64'(v2) << (2*w)) | (64'(v3) << (3*w));
        return r;
    endfunction

    function automatic rep_t mk(input logic [63:0] pv, input logic [63:0] pt,
        input logic fh, input logic [3:0] fc, input logic [15:0] ft);
        rep_t r;
        r.pv = pv; r.pt = pt; r.fh = fh; r.fc = fc; r.ft = ft;
        return r;
    endfunction

    // Monitor: 4-channel report handshakes
    always @(negedge clk) begin
        if (report_valid && report_ready) begin
            if (q4.size() == 0) begin
                chk("u4_unexpected_report", 64'd1, 64'd0);
            end else begin
                rep_t e;
                e = q4.pop_front();
                chk("u4_peak_values", 64'(peak_values), e.pv);
                chk("u4_peak_times", peak_times, e.pt);
                chk("u4_first_hit", 64'(first_hit), 64'(e.fh));
                chk("u4_first_ch", 64'(first_ch), 64'(e.fc));
                chk("u4_first_time", 64'(first_time), 64'(e.ft));
            end
        end
    end

    // Monitor: 3-channel report handshakes
    always @(negedge clk) begin
        if (s3_rv && s3_ready) begin
            if (q3.size() == 0) begin
                chk("u3_unexpected_report", 64'd1, 64'd0);
            end else begin
                rep_t e;
                e = q3.pop_front();
                chk("u3_peak_values", 64'(s3_pv), e.pv);
                chk("u3_peak_times", 64'(s3_pt), e.pt);
                chk("u3_first_hit", 64'(s3_fh), 64'(e.fh));
                chk("u3_first_ch", 64'(s3_fc), 64'(e.fc));
                chk("u3_first_time", 64'(s3_ft), 64'(e.ft));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input int d);
        sample_valid = 1'b1;
        sample_ch    = 2'(ch);
        sample_data  = 10'(d);
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic frame4(input int a, input int b, input int c, input int d);
        send(0, a); send(1, b); send(2, c); send(3, d);
    endtask

    task automatic send3(input int ch, input int d);
        s3_valid = 1'b1;
        s3_ch    = 2'(ch);
        s3_data  = 10'(d);
        tick();
        s3_valid = 1'b0;
    endtask

    task automatic go(input int thr);
        start     = 1'b1;
        threshold = 10'(thr);
        tick();
        start     = 1'b0;
    endtask

    initial begin
        logic ok;
        reset = 1'b1; start = 1'b0; sample_valid = 1'b0;
        sample_ch = '0; sample_data = '0; threshold = '0;
        report_ready = 1'b1;
        s3_reset = 1'b1; s3_start = 1'b0; s3_valid = 1'b0;
        s3_ch = '0; s3_data = '0; s3_thr = '0; s3_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0; s3_reset = 1'b0;

        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_report_valid", 64'(report_valid), 64'd0);
        chk("reset_outputs", 64'({peak_values, first_hit, first_ch}), 64'd0);
        chk("reset_times", peak_times, 64'd0);

        // Ramp on ch2 with a tie; nothing crosses threshold
        q4.push_back(mk(pk(10, 0, 0, 50, 0), pk(16, 0, 0, 1, 0), 1'b0, 4'd0, 16'd0));
        go(1023);
        chk("acq_busy", 64'(busy), 64'd1);
        frame4(0, 0, 10, 0);
        frame4(0, 0, 50, 0);
        frame4(0, 0, 50, 0);
        send(0, 0); send(1, 0); send(2, 20);
        chk("pre_last_report_valid", 64'(report_valid), 64'd0);
        send(3, 0);
        chk("report_valid_latency", 64'(report_valid), 64'd1);
        tick();
        chk("idle_after_handshake", 64'(busy), 64'd0);

        // Crossing on ch3 in frame 2, bigger later crossing on ch0
        report_ready = 1'b0;
        q4.push_back(mk(pk(10, 200, 99, 60, 120), pk(16, 3, 1, 2, 2), 1'b1, 4'd3, 16'd2));
        go(100);
        frame4(5, 6, 7, 8);
        frame4(9, 99, 3, 50);
        frame4(30, 40, 60, 120);
        frame4(200, 10, 10, 10);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            start = i[0];
            threshold = 10'd0;
            tick();
            if (!(busy && report_valid && first_hit && first_ch == 2'd3 &&
                  first_time == 16'd2 &&
                  64'(peak_values) == pk(10, 200, 99, 60, 120) &&
                  peak_times == pk(16, 3, 1, 2, 2)))
                ok = 1'b0;
        end
        start = 1'b0;
        chk("stall_stable", 64'(ok), 64'd1);
        report_ready = 1'b1;
        start = 1'b1;
        tick();
        chk("start_in_handshake_ignored", 64'(busy), 64'd0);
        threshold = 10'd60;
        tick();
        start = 1'b0;
        chk("start_after_handshake", 64'(busy), 64'd1);

        // Reset in frame 2 of an active window
        frame4(1, 2, 3, 900);
        frame4(4, 5, 6, 7);
        send(0, 500);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_report_valid", 64'(report_valid), 64'd0);
        chk("midrst_outputs",
            64'({peak_values, first_hit, first_ch, first_time}), 64'd0);
        chk("midrst_times", peak_times, 64'd0);

        // Clean window after reset: equal-to-threshold hit, tie on ch3,
        // and a sample issued with the start pulse that must be dropped
        q4.push_back(mk(pk(10, 50, 2, 3, 7), pk(16, 0, 3, 3, 1), 1'b1, 4'd0, 16'd0));
        sample_valid = 1'b1; sample_ch = 2'd1; sample_data = 10'd900;
        go(50);
        sample_valid = 1'b0;
        frame4(50, 0, 0, 0);
        frame4(0, 0, 0, 7);
        frame4(0, 0, 0, 7);
        frame4(1, 2, 3, 7);
        chk("clean_report_valid", 64'(report_valid), 64'd1);
        tick();

        // 3-channel: out-of-range channel index carries 1023
        q3.push_back(mk(pk(10, 8, 6, 7, 0), pk(16, 1, 0, 0, 0), 1'b0, 4'd0, 16'd0));
        s3_start = 1'b1; s3_thr = 10'd1023;
        tick();
        s3_start = 1'b0;
        send3(0, 5); send3(3, 1023); send3(1, 6); send3(2, 7);
        send3(3, 1023);
        send3(0, 8); send3(1, 1);
        chk("u3_pre_last_valid", 64'(s3_rv), 64'd0);
        send3(2, 2);
        chk("u3_report_valid", 64'(s3_rv), 64'd1);
        tick();
        chk("u3_idle", 64'(s3_busy), 64'd0);

        repeat (2) tick();
        chk("u4_reports_drained", 64'(q4.size()), 64'd0);
        chk("u3_reports_drained", 64'(q3.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multi_channel_peak_tracker.md
MULTI_CHANNEL_PEAK_TRACKER -- requirements
Module: multi_channel_peak_tracker

Interface
REQ-001 SHALL have parameter DATA_W, default 10, unsigned sample width.
REQ-002 SHALL have parameter NUM_CH, default 4, hydrophone channel count (2..16).
REQ-003 SHALL have parameter WIN_LEN, default 1024, frames per acquisition window (>=2).
REQ-004 SHALL have parameter CNT_W, default 16, frame-timestamp width; CH_W = clog2(NUM_CH), derived and not overridable.
REQ-005 SHALL have clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have start  input  1  one-cycle pulse that begins a window.
REQ-008 SHALL have sample_valid  input  1  sample_data/sample_ch qualify this cycle.
REQ-009 SHALL have sample_ch  input  CH_W  channel index of the current sample.
REQ-010 SHALL have sample_data  input  DATA_W  unsigned ADC sample.
REQ-011 SHALL have threshold  input  DATA_W  first-arrival threshold; sampled at start.
REQ-012 SHALL have report_ready  input  1  consumer accepts the report.
REQ-013 SHALL have busy  output  1  high in ACQUIRE and REPORT.
REQ-014 SHALL have report_valid  output  1  report fields are valid.
REQ-015 SHALL have peak_values  output  NUM_CH*DATA_W  per-channel maximum; channel k at bits [k*DATA_W +: DATA_W].
REQ-016 SHALL have peak_times  output  NUM_CH*CNT_W  frame index of each channel's maximum, same packing.
REQ-017 SHALL have first_ch  output  CH_W  channel that crossed threshold first.
REQ-018 SHALL have first_hit  output  1  some channel crossed threshold during the window.
REQ-019 SHALL have first_time  output  CNT_W  frame index of the first crossing.

Function
REQ-020 SHALL implement states IDLE, ACQUIRE, REPORT; IDLE->ACQUIRE on start; ACQUIRE->REPORT after the last frame; REPORT->IDLE in the cycle report_valid && report_ready.
REQ-021 SHALL, on start in IDLE, clear all peaks and times to 0, clear first_hit, first_ch and first_time, zero the frame counter, and latch threshold.
REQ-022 SHALL ignore start in ACQUIRE and REPORT.
REQ-023 SHALL ignore sample_valid in IDLE and REPORT, and in the same cycle as the accepted start.
REQ-024 SHALL ignore samples with sample_ch >= NUM_CH; such samples neither update state nor advance the frame.
REQ-025 SHALL, in ACQUIRE on a valid sample, replace channel peak and time with sample_data and the current frame index only when sample_data > stored peak (strict; ties keep earliest).
REQ-026 SHALL advance the frame counter by 1 on a valid sample with sample_ch == NUM_CH-1; the frame counter wraps modulo 2^CNT_W with no flag.
REQ-027 SHALL leave ACQUIRE on the cycle after accepting the channel NUM_CH-1 sample of frame WIN_LEN-1; report_valid is asserted the following cycle.
REQ-028 SHALL, while first_hit == 0, set first_hit=1, first_ch=sample_ch and first_time=frame index on the first valid sample with sample_data >= latched threshold; later crossings are ignored.
REQ-029 SHALL hold all report outputs stable from report_valid rise until handshake completion; outputs retain their values in IDLE until the next start.
REQ-030 SHALL deassert report_valid the cycle after the handshake; start in that cycle is ignored; start is accepted one cycle later.
REQ-031 SHALL treat samples as unsigned; no saturation or sign extension.

Reset
REQ-032 SHALL, on reset, enter IDLE and force busy, report_valid, first_hit to 0, and peak_values, peak_times, first_ch, first_time, frame counter to 0.
REQ-033 SHALL give reset priority over every other input in every state, including mid-ACQUIRE and during a pending report.

Verification
REQ-034 SHALL verify NUM_CH=4, WIN_LEN=4: ch2 ramp 10,50,50,20 and other channels 0 -> ch2 peak 50, time 1 (tie kept), others 0, report_valid 1 cycle after frame 3 ch3.
REQ-035 SHALL verify threshold 100: ch3 sees 120 in frame 2, ch0 sees 200 in frame 3 -> first_hit 1, first_ch 3, first_time 2; ch0 peak 200 time 3.
REQ-036 SHALL verify report_ready held low 20 cycles -> outputs stable, busy 1, start pulses ignored; ready high -> IDLE next cycle.
REQ-037 SHALL verify reset asserted in frame 2 of ACQUIRE -> next cycle busy 0, all outputs 0; a later start runs a full window cleanly.
REQ-038 SHALL verify NUM_CH=3 with sample_ch=3 samples of value 1023 -> no peak change, no frame advance.
REQ-039 SHALL verify all samples below threshold for a whole window -> first_hit 0, first_ch 0, first_time 0.
